// File: rtl/chaotic_pkg.sv
// chaotic_pkg: shared widths, constants and FSM states for the logistic-map cipher
package chaotic_pkg;
  localparam int X_W = 16;
  localparam int R_W = 8;
  localparam int P_W = 40;
  localparam int KEY_BYTE_MSB = 15;
  localparam logic [X_W-1:0] LMAP_ONE = 16'hFFFF;
  localparam logic [X_W-1:0] LMAP_HALF = 16'h7FFF;
  typedef enum logic [2:0] {IDLE, WARM_MUL, WARM_DIV, READY, MUL, DIV, OUT} state_t;
endpackage

// File: rtl/lmap_step_pipe.sv
// lmap_step_pipe: two-stage logistic-map step (product, then divide/round) owning the map state x
module lmap_step_pipe
  import chaotic_pkg::*;
(
  input  logic           clock,
  input  logic           reset,
  input  logic           load,
  input  logic [X_W-1:0] load_x,
  input  logic [R_W-1:0] r,
  input  logic           in_valid,
  output logic           out_valid,
  output logic [X_W-1:0] x
);
  logic [P_W-1:0] prod;
  logic           p_valid;
  logic [X_W-1:0] x_next;
  assign x_next = X_W'(({1'b0, prod} + (P_W+1)'(LMAP_HALF)) / (P_W+1)'(LMAP_ONE));
  // out_valid marks the edge on which the stage-2 result lands in x
  assign out_valid = p_valid;
  always_ff @(posedge clock) begin
    if (reset) begin
      prod <= '0;
      p_valid <= 1'b0;
      x <= '0;
    end else if (load) begin
      p_valid <= 1'b0;
      x <= load_x;
    end else begin
      p_valid <= in_valid;
      if (in_valid) prod <= P_W'(r) * P_W'(x) * P_W'(LMAP_ONE - x);
      if (p_valid) x <= x_next;
    end
  end
endmodule

// File: rtl/chaotic_lmap_decrypt.sv
// chaotic_lmap_decrypt: logistic-map keystream decryptor with seed load, warm-up and byte handshake
module chaotic_lmap_decrypt
  import chaotic_pkg::*;
#(
  parameter int WARMUP = 16,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             seed_load,
  input  logic [X_W-1:0]   seed_x,
  input  logic [R_W-1:0]   seed_r,
  output logic             seed_err,
  output logic             locked,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [7:0]       m_data,
  output logic [CNT_W-1:0] byte_count
);
  localparam int WC_W = WARMUP < 2 ? 1 : $clog2(WARMUP);
  state_t state, next;
  logic [WC_W-1:0] warm_cnt;
  logic [R_W-1:0] r;
  logic [7:0] ct;
  logic [X_W-1:0] x;
  logic seed_ok, step_valid, warm_last;
  assign seed_ok = seed_x != '0 && seed_x != LMAP_ONE;
  assign warm_last = int'(warm_cnt) + 1 == WARMUP;
  assign s_ready = state == READY;
  assign locked = state inside {READY, MUL, DIV, OUT};
  assign m_valid = state == OUT;
  assign m_data = m_valid ? ct ^ x[KEY_BYTE_MSB -: 8] : '0;
  lmap_step_pipe u_step (
    .clock(clock),
    .reset(reset),
    .load(seed_load && seed_ok),
    .load_x(seed_x),
    .r(r),
    .in_valid(!seed_load && (state == WARM_MUL || state == MUL)),
    .out_valid(step_valid),
    .x(x)
  );
  // a seed load overrides every state, including an in-flight byte
  always_comb begin
    next = state;
    if (seed_load) next = !seed_ok ? IDLE : WARMUP == 0 ? READY : WARM_MUL;
    else if (state == WARM_MUL) next = WARM_DIV;
    else if (state == WARM_DIV && step_valid) next = warm_last ? READY : WARM_MUL;
    else if (state == READY && s_valid) next = MUL;
    else if (state == MUL) next = DIV;
    else if (state == DIV && step_valid) next = OUT;
    else if (state == OUT && m_ready) next = READY;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      warm_cnt <= '0;
      r <= '0;
      ct <= '0;
      byte_count <= '0;
      seed_err <= 1'b0;
    end else begin
      state <= next;
      seed_err <= seed_load && !seed_ok;
      if (seed_load) begin
        byte_count <= '0;
        warm_cnt <= '0;
        if (seed_ok) r <= seed_r;
      end else begin
        if (state == WARM_DIV && step_valid) warm_cnt <= warm_cnt + WC_W'(1);
        if (state == READY && s_valid) ct <= s_data;
        if (state == OUT && m_ready) byte_count <= byte_count + CNT_W'(1);
      end
    end
  end
endmodule

// File: doc/chaotic_lmap_decrypt.md
Name: chaotic_lmap_decrypt

Overview:
- Receiver-side stream decryptor for the logistic-map chaotic cipher.
- Loads the shared secret: seed x0 (Q0.16) and map gain r. Discards a warm-up transient, then iterates the logistic map once per ciphertext byte.
- Keystream byte = iterate[15:8]; it is XORed with the ciphertext byte to recover plaintext.
- Sits between the link receive byte stream and the plaintext consumer. Its map step is bit-identical to the transmitter-side encryptor's.

Parameters:
- WARMUP, 16, map iterations discarded after seed load before the first byte is accepted (0 allowed).
- CNT_W, 16, width of the processed-byte counter.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- seed_load  in  1  single-cycle pulse: load seed_x and seed_r.
- seed_x  in  16  initial state x0, Q0.16 (65535 ≈ 1.0).
- seed_r  in  8  map gain r, unsigned integer.
- seed_err  out  1  one-cycle pulse: seed rejected.
- locked  out  1  warm-up complete; stream active.
- s_valid  in  1  ciphertext byte valid.
- s_ready  out  1  decryptor can accept a byte.
- s_data  in  8  ciphertext byte.
- m_valid  out  1  plaintext byte valid.
- m_ready  in  1  consumer accepts the byte.
- m_data  out  8  plaintext byte.
- byte_count  out  CNT_W  plaintext bytes delivered; wraps modulo 2^CNT_W.

Behaviour:
- Map step, fixed across the system:
  - P = r*x*(65535-x), computed at full 40-bit width with no truncation.
  - x' = ((P + 32767) / 65535), keeping bits [15:0].
  - Implemented as a 2-cycle pipeline: registered product, then registered divide/round.
- Reset values: seed_err=0, locked=0, s_ready=0, m_valid=0, m_data=0, byte_count=0. Internal x=0, r=0, state IDLE.
- States: IDLE, WARM_MUL, WARM_DIV, READY, MUL, DIV, OUT.
- IDLE:
  - s_ready=0; waits for seed_load.
  - If seed_x==0 or seed_x==65535 (fixed points), the seed is rejected: pulse seed_err for the next cycle and stay in IDLE.
  - Otherwise latch x=seed_x, r=seed_r, warm counter=0. Go to WARM_MUL, or to READY if WARMUP==0.
- WARM_MUL → WARM_DIV → (warm counter+1 == WARMUP ? READY : WARM_MUL).
  - One iteration takes 2 cycles; total warm-up is 2*WARMUP cycles.
  - Keystream is discarded during warm-up.
- READY:
  - locked=1, s_ready=1.
  - On s_valid&&s_ready at edge E0: latch s_data, go to MUL.
- MUL (E1): product registered.
- DIV (E2): x updated; m_data = latched_ct ^ x'[15:8]; m_valid=1; go to OUT.
- OUT:
  - m_valid and m_data are held stable until m_ready=1.
  - On the handshake edge: byte_count+1, m_valid=0, go to READY.
- Latency and throughput:
  - Input accept to m_valid is 2 cycles.
  - With m_ready held high, s_ready re-asserts 3 cycles after an accept: 1 byte per 3 cycles max.
  - s_ready=0 in every state except READY.
- seed_load priority:
  - seed_load has highest priority in every non-IDLE state: it aborts any in-flight byte and drops a pending m_valid without a handshake.
  - locked drops to 0 on the next edge, and byte_count clears to 0.
  - The seed is then validated and warm-up restarts as described for IDLE. A rejected seed returns to IDLE with locked=0.
- A held seed_load is treated as repeated loads; each asserted cycle restarts the load.
- reset mid-operation: everything returns to reset values on the next edge; any pending output is lost.
- locked stays 1 from the edge entering READY until a reload or reset.
- r>4 is legal: the result wraps modulo 2^16 with no saturation, matching the encryptor.

Decomposition:
- Package chaotic_pkg holds:
  - X_W=16, R_W=8, KEY_BYTE_MSB=15;
  - the state enum;
  - a constant LMAP_ONE=65535;
  - LMAP_HALF=32767.
- One sub-module, lmap_step_pipe: the 2-stage map step with a valid-in/valid-out strobe. The encryptor reuses it, which guarantees both ends compute identical keystreams.

Test Plan:
- Map vector:
  - Stimulus: seed x0=16384, r=4, WARMUP=0; send s_data=0x00 twice.
  - Required: x goes 16384→49152 (m_data=0xC0), then 49152→49150 (m_data=0xBF). m_valid rises 2 cycles after each accept.
- Fixed-point path:
  - Stimulus: x0=32768, r=4, WARMUP=1.
  - Required: the warm iterate is 65535. The first byte 0x5A gives x'=0 and output 0x5A. Every later keystream byte is 0x00.
- Seed rejection:
  - Stimulus: seed_load with seed_x=0, then with 65535.
  - Required: a seed_err pulse each time; locked, s_ready and m_valid all stay 0.
- Backpressure:
  - Stimulus: hold m_ready=0 for 10 cycles after m_valid rises.
  - Required: m_data stable, s_ready=0, byte_count unchanged. Releasing m_ready gives exactly one handshake, byte_count+1, and s_ready high the next cycle.
- Reload mid-byte:
  - Stimulus: assert seed_load during DIV.
  - Required: m_valid never asserts for that byte, byte_count=0, locked=0, and the warm-up of 2*WARMUP cycles is observed before s_ready.
- Round trip:
  - Stimulus: a 256-byte random message through the reference encryptor model with the same seed, then through the decryptor with random m_ready.
  - Required: output equals the plaintext and byte_count=256.
